// File: rtl/codec_pkg.sv
// Shared codec definitions: coefficient/symbol widths, the 8x8 zigzag scan
// tables, the encoder state enum and the symmetric level saturation function.
// Used by zigzag_rle_encoder and zigzag_addr (also reused by the decoder).
package codec_pkg;

    localparam int unsigned BLOCK_SIZE    = 8;
    localparam int unsigned NUM_COEFFS    = BLOCK_SIZE * BLOCK_SIZE;
    localparam int unsigned DCT_OUT_WIDTH = 54;
    localparam int unsigned LEVEL_WIDTH   = 16;
    localparam int unsigned RUN_WIDTH     = 6;
    localparam int unsigned IDX_WIDTH     = 6;
    localparam int unsigned POS_WIDTH     = 3;
    // One extra bit so a DC difference can never wrap before saturation.
    localparam int unsigned DIFF_WIDTH    = DCT_OUT_WIDTH + 1;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COEFFS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        EOB  = 2'd3
    } enc_state_t;

    // Zigzag scan order: entry k gives the [row][col] of the k-th scanned coefficient.
    localparam logic [POS_WIDTH-1:0] ZZ_ROW [NUM_COEFFS] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
        3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
    };

    localparam logic [POS_WIDTH-1:0] ZZ_COL [NUM_COEFFS] = '{
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
        3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
        3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
        3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
    };

    // Symmetric clamp; the most negative level code is never produced.
    function automatic logic signed [LEVEL_WIDTH-1:0] sat_level(
        input logic signed [DIFF_WIDTH-1:0] v
    );
        logic signed [DIFF_WIDTH-1:0] max_v;
        logic signed [DIFF_WIDTH-1:0] min_v;
        max_v = DIFF_WIDTH'((1 << (LEVEL_WIDTH - 1)) - 1);
        min_v = -max_v;
        if (v > max_v) begin
            sat_level = LEVEL_WIDTH'(max_v);
        end else if (v < min_v) begin
            sat_level = LEVEL_WIDTH'(min_v);
        end else begin
            sat_level = LEVEL_WIDTH'(v);
        end
    endfunction

endpackage

// File: rtl/zigzag_addr.sv
// Combinational zigzag scan address: idx -> {row, col} of the coefficient.
// Ports: idx (scan index 0..63), row_c / col_c (block position).
module zigzag_addr
    import codec_pkg::*;
(
    input  logic [IDX_WIDTH-1:0] idx,
    output logic [POS_WIDTH-1:0] row_c,
    output logic [POS_WIDTH-1:0] col_c
);

    assign row_c = ZZ_ROW[idx];
    assign col_c = ZZ_COL[idx];

endmodule

// File: rtl/zigzag_rle_encoder.sv
// Zigzag run-length encoder: captures an 8x8 block of quantized coefficients
// and emits (run, level) symbols in zigzag order, terminated by an EOB symbol.
// Ports: clk, rst_n (async active-low), frame_start (DC predictor clear),
//   block_valid/block_ready/coeff_in (block input handshake),
//   sym_valid/sym_ready/sym_run/sym_level/sym_eob (symbol stream),
//   block_done (one-cycle pulse when EOB is accepted).
// Build option: DC_DPCM_EN -- DC coded as difference from the previous
//   block's DC; when undefined the DC is coded directly and frame_start is unused.
module zigzag_rle_encoder
    import codec_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          block_valid,
    output logic                          block_ready,
    input  logic signed [DCT_OUT_WIDTH-1:0] coeff_in [BLOCK_SIZE][BLOCK_SIZE],
    output logic                          sym_valid,
    input  logic                          sym_ready,
    output logic [RUN_WIDTH-1:0]          sym_run,
    output logic signed [LEVEL_WIDTH-1:0] sym_level,
    output logic                          sym_eob,
    output logic                          block_done
);

    enc_state_t                     state_q, state_d;
    logic [IDX_WIDTH-1:0]           idx_q, idx_d;
    logic [RUN_WIDTH-1:0]           run_q, run_d;
    logic signed [DCT_OUT_WIDTH-1:0] coeff_q [BLOCK_SIZE][BLOCK_SIZE];
    logic signed [DCT_OUT_WIDTH-1:0] coeff_d [BLOCK_SIZE][BLOCK_SIZE];
    logic                           block_ready_q, block_ready_d;
    logic                           sym_valid_q, sym_valid_d;
    logic [RUN_WIDTH-1:0]           sym_run_q, sym_run_d;
    logic signed [LEVEL_WIDTH-1:0]  sym_level_q, sym_level_d;
    logic                           sym_eob_q, sym_eob_d;
    logic                           block_done_q, block_done_d;

    logic [POS_WIDTH-1:0]           zz_row_c, zz_col_c;
    logic signed [DCT_OUT_WIDTH-1:0] cur_coeff_c;
    logic signed [DIFF_WIDTH-1:0]   level_src_c;

    zigzag_addr u_zigzag_addr (
        .idx   (idx_q),
        .row_c (zz_row_c),
        .col_c (zz_col_c)
    );

    assign cur_coeff_c = coeff_q[zz_row_c][zz_col_c];

`ifdef DC_DPCM_EN
    logic signed [DCT_OUT_WIDTH-1:0] pred_q, pred_d;

    // DC is coded relative to the previous block's raw DC.
    assign level_src_c = (idx_q == '0) ? DIFF_WIDTH'(cur_coeff_c) - DIFF_WIDTH'(pred_q)
                                       : DIFF_WIDTH'(cur_coeff_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q <= '0;
        end else begin
            pred_q <= pred_d;
        end
    end
`else
    logic frame_start_unused;
    assign frame_start_unused = frame_start;
    assign level_src_c = DIFF_WIDTH'(cur_coeff_c);
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            run_q         <= '0;
            coeff_q       <= '{default: '0};
            block_ready_q <= 1'b1;
            sym_valid_q   <= 1'b0;
            sym_run_q     <= '0;
            sym_level_q   <= '0;
            sym_eob_q     <= 1'b0;
            block_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            run_q         <= run_d;
            coeff_q       <= coeff_d;
            block_ready_q <= block_ready_d;
            sym_valid_q   <= sym_valid_d;
            sym_run_q     <= sym_run_d;
            sym_level_q   <= sym_level_d;
            sym_eob_q     <= sym_eob_d;
            block_done_q  <= block_done_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        run_d         = run_q;
        coeff_d       = coeff_q;
        block_ready_d = 1'b0;
        sym_valid_d   = sym_valid_q;
        sym_run_d     = sym_run_q;
        sym_level_d   = sym_level_q;
        sym_eob_d     = sym_eob_q;
        block_done_d  = 1'b0;
`ifdef DC_DPCM_EN
        pred_d        = pred_q;
`endif

        case (state_q)
            IDLE: begin
                block_ready_d = 1'b1;
                if (block_valid) begin
                    coeff_d       = coeff_in;
                    idx_d         = '0;
                    run_d         = '0;
                    block_ready_d = 1'b0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if ((idx_q == '0) || (cur_coeff_c != '0)) begin
                    sym_valid_d = 1'b1;
                    sym_run_d   = run_q;
                    sym_level_d = sat_level(level_src_c);
                    sym_eob_d   = 1'b0;
                    state_d     = EMIT;
                end else if (idx_q == LAST_IDX) begin
                    // Trailing zeros collapse into the EOB symbol.
                    run_d       = '0;
                    sym_valid_d = 1'b1;
                    sym_run_d   = '0;
                    sym_level_d = '0;
                    sym_eob_d   = 1'b1;
                    state_d     = EOB;
                end else begin
                    run_d = run_q + RUN_WIDTH'(1);
                    idx_d = idx_q + IDX_WIDTH'(1);
                end
            end
            EMIT: begin
                if (sym_ready) begin
                    run_d = '0;
`ifdef DC_DPCM_EN
                    if (idx_q == '0) begin
                        pred_d = cur_coeff_c;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        sym_valid_d = 1'b1;
                        sym_run_d   = '0;
                        sym_level_d = '0;
                        sym_eob_d   = 1'b1;
                        state_d     = EOB;
                    end else begin
                        sym_valid_d = 1'b0;
                        idx_d       = idx_q + IDX_WIDTH'(1);
                        state_d     = SCAN;
                    end
                end
            end
            EOB: begin
                if (sym_ready) begin
                    sym_valid_d   = 1'b0;
                    sym_eob_d     = 1'b0;
                    block_done_d  = 1'b1;
                    block_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DC_DPCM_EN
        if (frame_start) begin
            pred_d = '0;
        end
`endif
    end

    assign block_ready = block_ready_q;
    assign sym_valid   = sym_valid_q;
    assign sym_run     = sym_run_q;
    assign sym_level   = sym_level_q;
    assign sym_eob     = sym_eob_q;
    assign block_done  = block_done_q;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Self-checking bench for zigzag_rle_encoder: directed and random blocks are
// compared against a reference model that derives the scan order from the
// anti-diagonal traversal and builds the expected symbol list with plain loops.
module tb_zigzag_rle_encoder;
    import codec_pkg::*;

    typedef logic signed [DCT_OUT_WIDTH-1:0] blk_t [BLOCK_SIZE][BLOCK_SIZE];
    typedef struct {
        int     run;
        longint level;
        bit     eob;
    } sym_t;

    logic                           clk;
    logic                           rst_n;
    logic                           frame_start;
    logic                           block_valid;
    logic                           block_ready;
    logic signed [DCT_OUT_WIDTH-1:0] coeff_in [BLOCK_SIZE][BLOCK_SIZE];
    logic                           sym_valid;
    logic                           sym_ready;
    logic [RUN_WIDTH-1:0]           sym_run;
    logic signed [LEVEL_WIDTH-1:0]  sym_level;
    logic                           sym_eob;
    logic                           block_done;

    int   vectors;
    int   miscompares;
    int   blk_count;
    int   zr [64];
    int   zc [64];
    sym_t exp_q [$];
    blk_t blk;
`ifdef DC_DPCM_EN
    longint model_pred;
`endif

    zigzag_rle_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .coeff_in    (coeff_in),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_run     (sym_run),
        .sym_level   (sym_level),
        .sym_eob     (sym_eob),
        .block_done  (block_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan order: walk anti-diagonals r+c=s, alternating direction.
    task automatic build_zigzag();
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8) ? s : 7; r >= 0 && (s - r) < 8; r--) begin
                    zr[k] = r; zc[k] = s - r; k++;
                end
            end else begin
                for (int r = (s < 8) ? 0 : s - 7; r < 8 && (s - r) >= 0; r++) begin
                    zr[k] = r; zc[k] = s - r; k++;
                end
            end
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    task automatic model_block(input blk_t b, input bit fs);
        longint v;
        int     run;
        exp_q.delete();
`ifdef DC_DPCM_EN
        if (fs) model_pred = 0;
        v = longint'(b[0][0]) - model_pred;
`else
        v = longint'(b[0][0]);
`endif
        exp_q.push_back('{0, sat(v), 1'b0});
        run = 0;
        for (int k = 1; k < 64; k++) begin
            v = longint'(b[zr[k]][zc[k]]);
            if (v == 0) begin
                run++;
            end else begin
                exp_q.push_back('{run, sat(v), 1'b0});
                run = 0;
            end
        end
        exp_q.push_back('{0, 0, 1'b1});
    endtask

    function automatic logic signed [DCT_OUT_WIDTH-1:0] rand_coeff();
        int     r;
        longint v;
        r = $urandom_range(0, 9);
        if (r < 7)       v = 0;
        else if (r == 7) v = longint'($urandom_range(0, 200)) - 100;
        else if (r == 8) v = longint'($urandom_range(0, 2000000)) - 1000000;
        else             v = {$urandom, $urandom};
        return DCT_OUT_WIDTH'(v);
    endfunction

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = rand_coeff();
    endtask

    task automatic fill_zero();
        blk = '{default: '0};
    endtask

    task automatic garbage_inputs();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                coeff_in[r][c] = DCT_OUT_WIDTH'({$urandom, $urandom});
    endtask

    task automatic idle(input int n);
        block_valid = 1'b0;
        repeat (n) begin
            sym_ready = 1'($urandom);
            @(negedge clk);
        end
        sym_ready = 1'b0;
    endtask

    // Called on a negedge with the DUT idle; returns on the block_done negedge.
    task automatic run_block(input blk_t b, input int stall_pct, input bit fs);
        int             cyc;
        bit             done;
        bit             stalled;
        logic [5:0]     p_run;
        logic signed [15:0] p_lvl;
        logic           p_eob;
        sym_t           e;
        blk_count++;
        vectors++;
        if (block_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_blk%0d: got %b expected 1", blk_count, block_ready);
        end
        model_block(b, fs);
        coeff_in    = b;
        block_valid = 1'b1;
        frame_start = fs;
        sym_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        garbage_inputs();
        done = 0; stalled = 0; cyc = 0;
        p_run = '0; p_lvl = '0; p_eob = 1'b0;
        while (!done && cyc < 400) begin
            if (cyc == 0) begin
                vectors++;
                if (sym_valid !== 1'b0 || block_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL scan_cycle blk%0d: got valid=%b done=%b expected 0 0",
                             blk_count, sym_valid, block_done);
                end
            end
            if (cyc == 1) begin
                vectors++;
                if (sym_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL dc_latency blk%0d: got valid=%b expected 1", blk_count, sym_valid);
                end
            end
            vectors++;
            if (block_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL ready_busy blk%0d cyc%0d: got %b expected 0", blk_count, cyc, block_ready);
            end
            if (stalled) begin
                vectors++;
                if (sym_valid !== 1'b1 || sym_run !== p_run || sym_level !== p_lvl || sym_eob !== p_eob) begin
                    miscompares++;
                    $display("FAIL stall_hold blk%0d cyc%0d: got v=%b (%0d,%0d,%b) expected v=1 (%0d,%0d,%b)",
                             blk_count, cyc, sym_valid, sym_run, sym_level, sym_eob, p_run, p_lvl, p_eob);
                end
            end
            if (sym_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_symbol blk%0d: got (%0d,%0d,%b) expected none",
                             blk_count, sym_run, sym_level, sym_eob);
                    break;
                end
                e = exp_q[0];
                if (sym_run !== 6'(e.run) || sym_level !== 16'(e.level) || sym_eob !== e.eob) begin
                    miscompares++;
                    $display("FAIL symbol blk%0d cyc%0d: got (%0d,%0d,eob=%b) expected (%0d,%0d,eob=%b)",
                             blk_count, cyc, sym_run, sym_level, sym_eob, e.run, e.level, e.eob);
                end
            end
            sym_ready = ($urandom_range(0, 99) >= stall_pct);
            stalled   = (sym_valid === 1'b1) && !sym_ready;
            p_run = sym_run; p_lvl = sym_level; p_eob = sym_eob;
            if (sym_valid === 1'b1 && sym_ready) begin
                if (sym_eob === 1'b1) done = 1;
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        sym_ready   = 1'b0;
        block_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL eob_timeout blk%0d: got no accepted EOB expected one within 400 cycles", blk_count);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_symbols blk%0d: got %0d left expected 0", blk_count, exp_q.size());
        end
        vectors++;
        if (block_done !== 1'b1 || block_ready !== 1'b1 || sym_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL block_done blk%0d: got done=%b ready=%b valid=%b expected 1 1 0",
                     blk_count, block_done, block_ready, sym_valid);
        end
`ifdef DC_DPCM_EN
        if (done) model_pred = longint'(b[0][0]);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; block_valid = 1'b0; sym_ready = 1'b0;
        coeff_in = '{default: '0};
        repeat (2) @(negedge clk);
        vectors++;
        if (block_ready !== 1'b1 || sym_valid !== 1'b0 || sym_run !== '0 || sym_level !== '0 ||
            sym_eob !== 1'b0 || block_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b v=%b run=%0d lvl=%0d eob=%b done=%b expected 1 0 0 0 0 0",
                     block_ready, sym_valid, sym_run, sym_level, sym_eob, block_done);
        end
        rst_n = 1'b1;
`ifdef DC_DPCM_EN
        model_pred = 0;
`endif
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        fill_zero();
        run_block(blk, 0, 1'b1);
        idle(2);
    endtask

    task automatic test_directed();
        fill_zero();
        blk[0][0] = 54'sd5;
        blk[0][1] = -54'sd3;
        blk[2][0] = 54'sd7;
        run_block(blk, 20, 1'b1);
        idle(2);
    endtask

    task automatic test_last_only();
        fill_zero();
        blk[0][0] = 54'sd33;
        blk[7][7] = 54'sd1;
        run_block(blk, 30, 1'b1);
        idle(1);
    endtask

    task automatic test_saturation();
        fill_zero();
        blk[0][0] = 54'sd1 <<< 40;
        blk[0][1] = -(54'sd1 <<< 40);
        blk[3][4] = 54'sd32767;
        blk[4][3] = -54'sd32768;
        run_block(blk, 10, 1'b1);
        idle(1);
    endtask

    task automatic test_random_stalls();
        for (int i = 0; i < 8; i++) begin
            fill_random();
            run_block(blk, 50, 1'($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            fill_random();
            run_block(blk, $urandom_range(0, 25), 1'b0);
        end
        idle(2);
    endtask

    task automatic test_dc_sequence();
        longint dcs [4];
        dcs = '{10, 14, 9, 4};
        for (int i = 0; i < 4; i++) begin
            fill_zero();
            blk[0][0] = DCT_OUT_WIDTH'(dcs[i]);
            run_block(blk, 0, (i == 0) || (i == 3));
            idle(1);
        end
    endtask

    task automatic test_reset_mid_emit();
        int cyc;
        fill_random();
        blk[0][0] = 54'sd1234;
        coeff_in    = blk;
        block_valid = 1'b1;
        sym_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        block_valid = 1'b0;
        cyc = 0;
        while (sym_valid !== 1'b1 && cyc < 5) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sym_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reach_emit: got valid=%b expected 1", sym_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (sym_valid !== 1'b0 || sym_run !== '0 || sym_level !== '0 || sym_eob !== 1'b0 ||
            block_ready !== 1'b1 || block_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_emit: got v=%b run=%0d lvl=%0d eob=%b rdy=%b done=%b expected 0 0 0 0 1 0",
                     sym_valid, sym_run, sym_level, sym_eob, block_ready, block_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DC_DPCM_EN
        model_pred = 0;
`endif
        @(negedge clk);
        fill_random();
        run_block(blk, 30, 1'b0);
        idle(1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        blk_count   = 0;
        build_zigzag();
        test_reset();
        test_all_zero();
        test_directed();
        test_last_only();
        test_saturation();
        test_random_stalls();
        test_back_to_back();
        test_dc_sequence();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
